// File: rtl/dsp_pkg.sv
// Shared DSP datapath constants and types for the FIR output stage.
package dsp_pkg;

    localparam int unsigned FIR_OUT_W = 39;
    localparam int unsigned SAMPLE_W  = 16;
    localparam int unsigned FRAC_BITS = 15;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } tx_state_t;

endpackage

// File: rtl/round_sat.sv
// Round-half-up, drop FRAC fraction bits and clamp a signed word to OUT_W bits.
module round_sat #(
    parameter int unsigned IN_W  = 39,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned FRAC  = 15
) (
    input  logic signed [IN_W-1:0]  i_data,
    output logic        [OUT_W-1:0] o_word,
    output logic                    o_clip
);

    localparam int unsigned EXT_W = IN_W + 1;
    localparam logic        [EXT_W-1:0] HALF  = EXT_W'(64'd1 << (FRAC - 1));
    localparam logic signed [EXT_W-1:0] MAX_S = EXT_W'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [EXT_W-1:0] MIN_S = ~MAX_S;

    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_shr;

    // One guard bit keeps the rounding add from overflowing at the top of range.
    assign w_ext = {i_data[IN_W-1], i_data} + HALF;
    assign w_shr = w_ext >>> FRAC;

    always_comb begin
        o_word = w_shr[OUT_W-1:0];
        o_clip = 1'b0;
        if (w_shr > MAX_S) begin
            o_word = MAX_S[OUT_W-1:0];
            o_clip = 1'b1;
        end else if (w_shr < MIN_S) begin
            o_word = MIN_S[OUT_W-1:0];
            o_clip = 1'b1;
        end
    end

endmodule

// File: rtl/fir_sample_tx.sv
// FIR output stage: round/saturate the accumulator, buffer one sample and
// shift it MSB-first onto a sclk/sdata/fs DAC link.
module fir_sample_tx
    import dsp_pkg::*;
#(
    parameter int unsigned IN_W    = FIR_OUT_W,
    parameter int unsigned OUT_W   = SAMPLE_W,
    parameter int unsigned FRAC    = FRAC_BITS,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic signed [IN_W-1:0] data_in,
    input  logic                   ovr_clr,
    output logic                   sclk,
    output logic                   sdata,
    output logic                   fs,
    output logic                   busy,
    output logic                   sat,
    output logic                   overrun
);

    localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
    localparam int unsigned BIT_W = $clog2(OUT_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(CLK_DIV);
    localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(OUT_W - 1);

    tx_state_t        r_state, w_state_nxt;
    logic [OUT_W-1:0] r_buf, w_buf_nxt;
    logic             r_buf_valid, w_buf_valid_nxt;
    logic [OUT_W-1:0] r_shift, w_shift_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic [BIT_W-1:0] r_bit, w_bit_nxt;
    logic             r_sclk, w_sclk_nxt;
    logic             r_sdata, w_sdata_nxt;
    logic             r_fs, w_fs_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_sat, w_sat_nxt;
    logic             r_overrun, w_overrun_nxt;
    logic [OUT_W-1:0] w_word;
    logic             w_clip;
    logic             w_drain;

    round_sat #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .FRAC  (FRAC)
    ) u_round_sat (
        .i_data (data_in),
        .o_word (w_word),
        .o_clip (w_clip)
    );

    assign w_drain = (r_state == LOAD);

    // Next state, buffer, shifter and next-cycle link outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_buf_nxt       = r_buf;
        w_buf_valid_nxt = r_buf_valid;
        w_shift_nxt     = r_shift;
        w_div_nxt       = r_div;
        w_bit_nxt       = r_bit;
        w_overrun_nxt   = r_overrun;

        if (ovr_clr) w_overrun_nxt = 1'b0;
        if (w_drain) w_buf_valid_nxt = 1'b0;
        if (ena) begin
            w_buf_nxt       = w_word;
            w_buf_valid_nxt = 1'b1;
            if (r_buf_valid && !w_drain) w_overrun_nxt = 1'b1;
        end

        // A strobe this cycle counts as a pending word so LOAD follows immediately.
        case (r_state)
            IDLE: begin
                if (r_buf_valid || ena) w_state_nxt = LOAD;
            end
            LOAD: begin
                w_state_nxt = SHIFT;
                w_shift_nxt = r_buf;
                w_bit_nxt   = BIT_MSB;
                w_div_nxt   = '0;
            end
            SHIFT: begin
                if (r_div == DIV_LAST) begin
                    w_div_nxt = '0;
                    if (r_bit == '0) begin
                        w_state_nxt = (r_buf_valid || ena) ? LOAD : IDLE;
                    end else begin
                        w_bit_nxt   = r_bit - BIT_W'(1);
                        w_shift_nxt = {r_shift[OUT_W-2:0], 1'b0};
                    end
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_sclk_nxt  = (w_state_nxt == SHIFT) && (w_div_nxt >= DIV_HIGH);
        w_sdata_nxt = (w_state_nxt == SHIFT) && w_shift_nxt[OUT_W-1];
        w_fs_nxt    = (w_state_nxt == SHIFT) && (w_bit_nxt == BIT_MSB);
        w_busy_nxt  = (w_state_nxt != IDLE) || w_buf_valid_nxt;
        w_sat_nxt   = ena && w_clip;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_buf       <= '0;
            r_buf_valid <= 1'b0;
            r_shift     <= '0;
            r_div       <= '0;
            r_bit       <= '0;
            r_sclk      <= 1'b0;
            r_sdata     <= 1'b0;
            r_fs        <= 1'b0;
            r_busy      <= 1'b0;
            r_sat       <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_buf       <= w_buf_nxt;
            r_buf_valid <= w_buf_valid_nxt;
            r_shift     <= w_shift_nxt;
            r_div       <= w_div_nxt;
            r_bit       <= w_bit_nxt;
            r_sclk      <= w_sclk_nxt;
            r_sdata     <= w_sdata_nxt;
            r_fs        <= w_fs_nxt;
            r_busy      <= w_busy_nxt;
            r_sat       <= w_sat_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    assign sclk    = r_sclk;
    assign sdata   = r_sdata;
    assign fs      = r_fs;
    assign busy    = r_busy;
    assign sat     = r_sat;
    assign overrun = r_overrun;

endmodule

// File: doc/fir_sample_tx.md
Name: fir_sample_tx

Overview:
- Output end of the FIR datapath. Captures the filter's 39-bit accumulator result on a strobe, then rounds and saturates it to a 16-bit sample.
- Serializes the sample MSB-first onto a 3-wire DAC link (sclk, sdata, fs) with a one-deep holding buffer.
- Sits directly downstream of fir. The integrator drives ena one cycle after fir's ena, so fir.out is settled when captured.

Parameters:
IN_W, 39, width of data_in (FIR accumulator width)
OUT_W, 16, serialized sample width
FRAC, 15, fractional bits dropped (Q15 taps)
CLK_DIV, 4, clk cycles per sclk half-period (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
ena  input  1  one-cycle strobe: data_in is valid this cycle
data_in  input  IN_W  signed FIR result
ovr_clr  input  1  synchronous clear of overrun
sclk  output  1  serial bit clock, idles low
sdata  output  1  serial data, MSB first
fs  output  1  frame sync, high during MSB bit period
busy  output  1  frame in progress or buffer occupied
sat  output  1  one-cycle pulse: captured sample was clipped
overrun  output  1  sticky: buffered sample was overwritten

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0, state is IDLE, buffer is empty, all counters are 0. Applies mid-frame too; the frame is aborted and not resumed.
- Arithmetic (combinational on data_in):
  - Sign-extend to IN_W+1 bits and add 2^(FRAC-1) (round half up).
  - Arithmetic shift right by FRAC.
  - Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - sat is asserted the cycle after the ena that captured a clipped value.
- Capture: on ena, write the rounded word into the holding buffer and set buf_valid.
  - If buf_valid is already 1 and the buffer is not being drained this cycle: overwrite and set overrun.
  - ena in the same cycle as a drain: the new word lands in the buffer, no overrun.
- overrun clears on ovr_clr. If ovr_clr and a new overrun event occur in the same cycle, set wins.
- FSM:
  - IDLE: sclk=0, sdata=0, fs=0. When buf_valid, go to LOAD.
  - LOAD (1 cycle): move buffer into the shift register, clear buf_valid, bit_cnt=OUT_W-1, div_cnt=0. Next state is SHIFT.
  - SHIFT: each bit period is 2*CLK_DIV clocks.
    - sclk is low for the first CLK_DIV clocks and high for the second.
    - sdata changes only at bit-period start (sclk falling edge or frame start) and is stable across the sclk rising edge.
    - fs=1 for exactly the bit period of the MSB.
  - End of the last bit period: if buf_valid, go to LOAD, else IDLE. Exactly one LOAD cycle separates back-to-back frames.
- Latency: ena at cycle T (IDLE, buffer empty) → buffer at T+1 → LOAD at T+1 → MSB on sdata with fs=1 at T+2 → first sclk rise at T+2+CLK_DIV.
- Frame length: OUT_W*2*CLK_DIV clocks (128 at defaults), plus 1 LOAD cycle.
- busy = (state != IDLE) | buf_valid.
- ena while IDLE and buffer empty never sets overrun.

Decomposition:
- dsp_pkg holds:
  - constants FIR_OUT_W=39, SAMPLE_W=16, FRAC_BITS=15
  - typedef sample_t (signed [15:0])
  - typedef tx_state_t enum {IDLE, LOAD, SHIFT}
- One sub-module: round_sat (purely combinational, params IN_W/OUT_W/FRAC, outputs word and clip flag). It is reusable by later decimator blocks.
- FSM, divider, bit counter, buffer and shifter live in fir_sample_tx.

Test Plan:
- Nominal word: data_in=100<<15 with ena.
  - fs high for the first bit only.
  - Bits sampled on sclk rise read 0x0064.
  - sat=0, busy drops 129 clocks after LOAD.
- Rounding:
  - (5<<15)+16384 → 6; (5<<15)+16383 → 5.
  - -16384 → 0; -16385 → 0xFFFF (-1).
- Saturation:
  - 40000<<15 → 0x7FFF with one sat pulse.
  - -(40000<<15) → 0x8000 with one sat pulse.
  - (32767<<15) → 0x7FFF with no sat.
- Back-to-back:
  - ena every 129 clocks with 0x1111 then 0x2222 (scaled by 2^15) → contiguous frames separated by 1 LOAD cycle, overrun=0.
  - Three ena within one frame (A, B, C) → frames A then C, overrun=1.
  - Then ovr_clr → overrun=0.
- Reset mid-frame: drop rst at bit 7 of a frame.
  - sclk, sdata, fs and busy are 0 asynchronously, within the same cycle.
  - After release, a new ena produces a clean full frame.
- Edge timing: CLK_DIV=1 → sclk toggles every clock, frame is 32 clocks. Also check simultaneous ena and LOAD, which must give no overrun.
